apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_apb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter between two APB requesters and one shared APB completer.
// Define APB_ARBITER_TIMEOUT_EN to build in the ACCESS-phase watchdog.
module apb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int USER_WIDTH     = 0,
    parameter int TIMEOUT_CYCLES = 255,
    // User ports keep one bit when USER_WIDTH is 0 so the port list stays legal
    localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  preset_n,

    input  logic                  up0_psel,
    input  logic                  up0_penable,
    input  logic                  up0_pwrite,
    input  logic [ADDR_WIDTH-1:0] up0_paddr,
    input  logic [DATA_WIDTH-1:0] up0_pwdata,
    input  logic [SW-1:0]         up0_pstrb,
    input  logic [2:0]            up0_pprot,
    input  logic                  up0_pwakeup,
    input  logic [UW-1:0]         up0_pauser,
    input  logic [UW-1:0]         up0_pwuser,
    output logic                  up0_pready,
    output logic [DATA_WIDTH-1:0] up0_prdata,
    output logic                  up0_pslverr,
    output logic [UW-1:0]         up0_pruser,
    output logic [UW-1:0]         up0_pbuser,

    input  logic                  up1_psel,
    input  logic                  up1_penable,
    input  logic                  up1_pwrite,
    input  logic [ADDR_WIDTH-1:0] up1_paddr,
    input  logic [DATA_WIDTH-1:0] up1_pwdata,
    input  logic [SW-1:0]         up1_pstrb,
    input  logic [2:0]            up1_pprot,
    input  logic                  up1_pwakeup,
    input  logic [UW-1:0]         up1_pauser,
    input  logic [UW-1:0]         up1_pwuser,
    output logic                  up1_pready,
    output logic [DATA_WIDTH-1:0] up1_prdata,
    output logic                  up1_pslverr,
    output logic [UW-1:0]         up1_pruser,
    output logic [UW-1:0]         up1_pbuser,

    output logic                  down_pclk,
    output logic                  down_preset_n,
    output logic                  down_psel,
    output logic                  down_penable,
    output logic                  down_pwrite,
    output logic [ADDR_WIDTH-1:0] down_paddr,
    output logic [DATA_WIDTH-1:0] down_pwdata,
    output logic [SW-1:0]         down_pstrb,
    output logic [2:0]            down_pprot,
    output logic                  down_pwakeup,
    output logic [UW-1:0]         down_pauser,
    output logic [UW-1:0]         down_pwuser,
    input  logic                  down_pready,
    input  logic [DATA_WIDTH-1:0] down_prdata,
    input  logic                  down_pslverr,
    input  logic [UW-1:0]         down_pruser,
    input  logic [UW-1:0]         down_pbuser
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    sel;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           strb_q, strb_d;
    logic [2:0]              prot_q, prot_d;
    logic [UW-1:0]           auser_q, auser_d;
    logic [UW-1:0]           wuser_q, wuser_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    slverr_q, slverr_d;
    logic [UW-1:0]           ruser_q, ruser_d;
    logic [UW-1:0]           buser_q, buser_d;
    logic                    cpl;

`ifdef APB_ARBITER_TIMEOUT_EN
    logic [15:0]             wdog_q, wdog_d;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    // Upstream penable carries no information the arbiter needs beyond psel
    logic unused_inputs;
    assign unused_inputs = up0_penable ^ up1_penable;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sel          = 1'b0;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        prot_d       = prot_q;
        auser_d      = auser_q;
        wuser_d      = wuser_q;
        rdata_d      = rdata_q;
        slverr_d     = slverr_q;
        ruser_d      = ruser_q;
        buser_d      = buser_q;
`ifdef APB_ARBITER_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (up0_psel || up1_psel) begin
                    // On a tie the port that did not win last time gets the bus
                    sel          = (up0_psel && up1_psel) ? ~last_grant_q : up1_psel;
                    grant_d      = sel;
                    last_grant_d = sel;
                    write_d      = sel ? up1_pwrite : up0_pwrite;
                    addr_d       = sel ? up1_paddr  : up0_paddr;
                    wdata_d      = sel ? up1_pwdata : up0_pwdata;
                    strb_d       = sel ? up1_pstrb  : up0_pstrb;
                    prot_d       = sel ? up1_pprot  : up0_pprot;
                    auser_d      = sel ? up1_pauser : up0_pauser;
                    wuser_d      = sel ? up1_pwuser : up0_pwuser;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
`ifdef APB_ARBITER_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (down_pready) begin
                    rdata_d  = down_prdata;
                    slverr_d = down_pslverr;
                    ruser_d  = down_pruser;
                    buser_d  = down_pbuser;
                    state_d  = COMPLETE;
                end
`ifdef APB_ARBITER_TIMEOUT_EN
                else begin
                    wdog_d = wdog_q + 16'd1;
                    // A stuck completer is answered with an error so the requester is released
                    if (wdog_d == 16'(TIMEOUT_CYCLES)) begin
                        rdata_d  = '0;
                        slverr_d = 1'b1;
                        ruser_d  = '0;
                        buser_d  = '0;
                        state_d  = COMPLETE;
                    end
                end
`endif
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            prot_q       <= '0;
            auser_q      <= '0;
            wuser_q      <= '0;
            rdata_q      <= '0;
            slverr_q     <= 1'b0;
            ruser_q      <= '0;
            buser_q      <= '0;
`ifdef APB_ARBITER_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            prot_q       <= prot_d;
            auser_q      <= auser_d;
            wuser_q      <= wuser_d;
            rdata_q      <= rdata_d;
            slverr_q     <= slverr_d;
            ruser_q      <= ruser_d;
            buser_q      <= buser_d;
`ifdef APB_ARBITER_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign cpl = (state_q == COMPLETE);

    // A requester that dropped psel while pending no longer receives its response
    assign up0_pready  = cpl && !grant_q && up0_psel;
    assign up0_prdata  = up0_pready ? rdata_q  : '0;
    assign up0_pslverr = up0_pready ? slverr_q : 1'b0;
    assign up0_pruser  = up0_pready ? ruser_q  : '0;
    assign up0_pbuser  = up0_pready ? buser_q  : '0;

    assign up1_pready  = cpl && grant_q && up1_psel;
    assign up1_prdata  = up1_pready ? rdata_q  : '0;
    assign up1_pslverr = up1_pready ? slverr_q : 1'b0;
    assign up1_pruser  = up1_pready ? ruser_q  : '0;
    assign up1_pbuser  = up1_pready ? buser_q  : '0;

    assign down_pclk     = pclk;
    assign down_preset_n = preset_n;
    assign down_psel     = (state_q == SETUP) || (state_q == ACCESS);
    assign down_penable  = (state_q == ACCESS);
    assign down_pwrite   = write_q;
    assign down_paddr    = addr_q;
    assign down_pwdata   = wdata_q;
    assign down_pstrb    = strb_q;
    assign down_pprot    = prot_q;
    assign down_pauser   = auser_q;
    assign down_pwuser   = wuser_q;
    assign down_pwakeup  = up0_pwakeup | up1_pwakeup;

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: directed transfers, expected responses queued, monitors compare.
module tb_apb_arbiter;

    logic        pclk = 1'b0;
    logic        preset_n;

    logic        up0_psel, up0_penable, up0_pwrite, up0_pwakeup;
    logic [15:0] up0_paddr;
    logic [31:0] up0_pwdata;
    logic [3:0]  up0_pstrb;
    logic [2:0]  up0_pprot;
    logic        up0_pauser, up0_pwuser;
    logic        up0_pready, up0_pslverr, up0_pruser, up0_pbuser;
    logic [31:0] up0_prdata;

    logic        up1_psel, up1_penable, up1_pwrite, up1_pwakeup;
    logic [15:0] up1_paddr;
    logic [31:0] up1_pwdata;
    logic [3:0]  up1_pstrb;
    logic [2:0]  up1_pprot;
    logic        up1_pauser, up1_pwuser;
    logic        up1_pready, up1_pslverr, up1_pruser, up1_pbuser;
    logic [31:0] up1_prdata;

    logic        down_pclk, down_preset_n, down_psel, down_penable, down_pwrite, down_pwakeup;
    logic [15:0] down_paddr;
    logic [31:0] down_pwdata;
    logic [3:0]  down_pstrb;
    logic [2:0]  down_pprot;
    logic        down_pauser, down_pwuser;
    logic        down_pready, down_pslverr, down_pruser, down_pbuser;
    logic [31:0] down_prdata;

    apb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .USER_WIDTH(0), .TIMEOUT_CYCLES(8)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .up0_psel(up0_psel), .up0_penable(up0_penable), .up0_pwrite(up0_pwrite),
        .up0_paddr(up0_paddr), .up0_pwdata(up0_pwdata), .up0_pstrb(up0_pstrb),
        .up0_pprot(up0_pprot), .up0_pwakeup(up0_pwakeup), .up0_pauser(up0_pauser),
        .up0_pwuser(up0_pwuser), .up0_pready(up0_pready), .up0_prdata(up0_prdata),
        .up0_pslverr(up0_pslverr), .up0_pruser(up0_pruser), .up0_pbuser(up0_pbuser),
        .up1_psel(up1_psel), .up1_penable(up1_penable), .up1_pwrite(up1_pwrite),
        .up1_paddr(up1_paddr), .up1_pwdata(up1_pwdata), .up1_pstrb(up1_pstrb),
        .up1_pprot(up1_pprot), .up1_pwakeup(up1_pwakeup), .up1_pauser(up1_pauser),
        .up1_pwuser(up1_pwuser), .up1_pready(up1_pready), .up1_prdata(up1_prdata),
        .up1_pslverr(up1_pslverr), .up1_pruser(up1_pruser), .up1_pbuser(up1_pbuser),
        .down_pclk(down_pclk), .down_preset_n(down_preset_n), .down_psel(down_psel),
        .down_penable(down_penable), .down_pwrite(down_pwrite), .down_paddr(down_paddr),
        .down_pwdata(down_pwdata), .down_pstrb(down_pstrb), .down_pprot(down_pprot),
        .down_pwakeup(down_pwakeup), .down_pauser(down_pauser), .down_pwuser(down_pwuser),
        .down_pready(down_pready), .down_prdata(down_prdata), .down_pslverr(down_pslverr),
        .down_pruser(down_pruser), .down_pbuser(down_pbuser)
    );

    always #5 pclk = ~pclk;

    typedef struct { int port; logic [31:0] rdata; logic err; bit chk_rdy; } up_exp_t;
    typedef struct { logic wr; logic [15:0] addr; logic [31:0] wdata; logic [3:0] strb; } dn_exp_t;

    up_exp_t     exp_up[$];
    dn_exp_t     exp_dn[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          dn_rdy_cyc = -10;
    int          wait_states = 0;
    bit          never_ready = 0;
    logic [31:0] resp_data = '0;
    logic        resp_err = 1'b0;
    logic [15:0] cur_addr;
    logic [31:0] cur_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Completer model: pready after wait_states ACCESS cycles
    initial begin
        int acc;
        acc = 0;
        down_pready = 0; down_prdata = '0; down_pslverr = 0; down_pruser = 0; down_pbuser = 0;
        forever begin
            @(negedge pclk);
            if (preset_n && down_psel && down_penable && !never_ready) begin
                if (acc >= wait_states) begin
                    down_pready = 1; down_prdata = resp_data; down_pslverr = resp_err;
                    dn_rdy_cyc = cyc;
                end else begin
                    down_pready = 0;
                    acc++;
                end
            end else begin
                down_pready = 0; down_prdata = '0; down_pslverr = 0;
                acc = 0;
            end
        end
    end

    // Downstream monitor: transfer order, fields and ACCESS-phase stability
    initial forever begin
        @(negedge pclk);
        if (preset_n && down_psel && !down_penable) begin
            if (exp_dn.size() == 0) begin
                check("unexpected_down_setup", 1, 0);
            end else begin
                dn_exp_t e;
                e = exp_dn.pop_front();
                check("down_pwrite", down_pwrite, e.wr);
                check("down_paddr", down_paddr, e.addr);
                check("down_pwdata", down_pwdata, e.wdata);
                check("down_pstrb", down_pstrb, e.strb);
                check("down_pprot", down_pprot, 3'b010);
            end
            cur_addr = down_paddr;
            cur_wdata = down_pwdata;
        end else if (preset_n && down_psel && down_penable) begin
            check("access_paddr_stable", down_paddr, cur_addr);
            check("access_pwdata_stable", down_pwdata, cur_wdata);
        end
    end

    // Upstream monitor: pops the scoreboard whenever either port sees pready
    initial forever begin
        @(negedge pclk);
        if (preset_n && (up0_pready || up1_pready)) begin
            int p;
            p = up1_pready ? 1 : 0;
            check("single_pready", {up0_pready, up1_pready} == 2'b11, 0);
            if (exp_up.size() == 0) begin
                check("unexpected_pready", 1, 0);
            end else begin
                up_exp_t e;
                e = exp_up.pop_front();
                check("resp_port", p, e.port);
                check("resp_prdata", p ? up1_prdata : up0_prdata, e.rdata);
                check("resp_pslverr", p ? up1_pslverr : up0_pslverr, e.err);
                check("other_quiet", p ? {up0_pready, up0_pslverr, up0_prdata}
                                       : {up1_pready, up1_pslverr, up1_prdata}, 0);
                if (e.chk_rdy) check("pready_after_down", cyc, dn_rdy_cyc + 1);
            end
        end
    end

    task automatic set_port(input int port, input logic sel, input logic wr,
                            input logic [15:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            up0_psel = sel; up0_pwrite = wr; up0_paddr = addr; up0_pwdata = wdata;
            up0_pstrb = wr ? 4'hF : 4'h0;
        end else begin
            up1_psel = sel; up1_pwrite = wr; up1_paddr = addr; up1_pwdata = wdata;
            up1_pstrb = wr ? 4'hF : 4'h0;
        end
    endtask

    task automatic do_xfer(input int port, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wdata, input int exp_lat);
        int start;
        bit got;
        @(posedge pclk); #1;
        set_port(port, 1'b1, wr, addr, wdata);
        start = cyc;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk);
            if ((port == 0 && up0_pready) || (port == 1 && up1_pready)) got = 1;
        end
        check($sformatf("pready_seen_p%0d", port), got, 1);
        check($sformatf("latency_p%0d", port), cyc - start, exp_lat);
        @(posedge pclk); #1;
        set_port(port, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    function automatic dn_exp_t dn(input logic wr, input logic [15:0] a, input logic [31:0] d);
        dn_exp_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.strb = wr ? 4'hF : 4'h0;
        return e;
    endfunction

    function automatic up_exp_t up(input int p, input logic [31:0] d, input logic err, input bit c);
        up_exp_t e;
        e.port = p; e.rdata = d; e.err = err; e.chk_rdy = c;
        return e;
    endfunction

    initial begin
        preset_n = 0;
        up0_penable = 0; up0_pwakeup = 0; up0_pprot = 3'b010; up0_pauser = 0; up0_pwuser = 0;
        up1_penable = 0; up1_pwakeup = 0; up1_pprot = 3'b010; up1_pauser = 0; up1_pwuser = 0;
        set_port(0, 0, 0, 16'h0, 32'h0);
        set_port(1, 0, 0, 16'h0, 32'h0);
        #7;
        check("rst_down_psel", down_psel, 0);
        check("rst_down_penable", down_penable, 0);
        check("rst_down_preset_n", down_preset_n, 0);
        check("rst_up_pready", {up0_pready, up1_pready}, 0);
        check("rst_up_resp", {up0_prdata, up0_pslverr, up0_pruser, up0_pbuser,
                              up1_prdata, up1_pslverr, up1_pruser, up1_pbuser}, 0);
        check("down_pclk", down_pclk, pclk);
        up1_pwakeup = 1; #1;
        check("pwakeup_or_1", down_pwakeup, 1);
        up1_pwakeup = 0; #1;
        check("pwakeup_or_0", down_pwakeup, 0);
        repeat (2) @(negedge pclk);
        preset_n = 1;

        // Tie from reset: port 0 first, port 1 next
        resp_data = 32'h0000_00AA; resp_err = 0; wait_states = 0;
        exp_dn.push_back(dn(1, 16'h0004, 32'h11)); exp_dn.push_back(dn(1, 16'h0008, 32'h22));
        exp_up.push_back(up(0, 32'hAA, 0, 1));     exp_up.push_back(up(1, 32'hAA, 0, 1));
        fork
            do_xfer(0, 1, 16'h0004, 32'h11, 3);
            do_xfer(1, 1, 16'h0008, 32'h22, 7);
        join

        // Tie after a port-1 grant: port 0 wins again
        resp_data = 32'h1234_5678;
        exp_dn.push_back(dn(0, 16'h0030, 32'h0)); exp_dn.push_back(dn(0, 16'h0034, 32'h0));
        exp_up.push_back(up(0, 32'h1234_5678, 0, 1)); exp_up.push_back(up(1, 32'h1234_5678, 0, 1));
        fork
            do_xfer(0, 0, 16'h0030, 32'h0, 3);
            do_xfer(1, 0, 16'h0034, 32'h0, 7);
        join

        // Single read, minimum latency
        resp_data = 32'hDEAD_BEEF;
        exp_dn.push_back(dn(0, 16'h0010, 32'h0));
        exp_up.push_back(up(0, 32'hDEAD_BEEF, 0, 1));
        do_xfer(0, 0, 16'h0010, 32'h0, 3);

        // Tie after a port-0 grant: port 1 first
        resp_data = 32'h0;
        exp_dn.push_back(dn(1, 16'h0044, 32'h66)); exp_dn.push_back(dn(1, 16'h0040, 32'h55));
        exp_up.push_back(up(1, 32'h0, 0, 1));      exp_up.push_back(up(0, 32'h0, 0, 1));
        fork
            do_xfer(0, 1, 16'h0040, 32'h55, 7);
            do_xfer(1, 1, 16'h0044, 32'h66, 3);
        join

        // Five wait states
        resp_data = 32'h0BAD_F00D; wait_states = 5;
        exp_dn.push_back(dn(1, 16'h0050, 32'hCAFE_0001));
        exp_up.push_back(up(1, 32'h0BAD_F00D, 0, 1));
        do_xfer(1, 1, 16'h0050, 32'hCAFE_0001, 8);
        wait_states = 0;

        // Error pass-through
        resp_data = 32'h77; resp_err = 1;
        exp_dn.push_back(dn(0, 16'h0060, 32'h0));
        exp_up.push_back(up(0, 32'h77, 1, 1));
        do_xfer(0, 0, 16'h0060, 32'h0, 3);
        resp_err = 0;

`ifdef APB_ARBITER_TIMEOUT_EN
        // Completer never ready: watchdog fires after 8 ACCESS cycles
        never_ready = 1;
        exp_dn.push_back(dn(0, 16'h0068, 32'h0));
        exp_up.push_back(up(0, 32'h0, 1, 0));
        do_xfer(0, 0, 16'h0068, 32'h0, 10);
        never_ready = 0;
`endif

        // Reset during an up1 ACCESS phase
        wait_states = 20;
        exp_dn.push_back(dn(1, 16'h0080, 32'h9));
        @(posedge pclk); #1;
        set_port(1, 1, 1, 16'h0080, 32'h9);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge pclk);
                if (down_penable) seen = 1;
            end
            check("reached_access", seen, 1);
        end
        #1;
        preset_n = 0;
        set_port(1, 0, 0, 16'h0, 32'h0);
        #1;
        check("rst_async_down_psel", {down_psel, down_penable}, 0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset_n = 1;
        wait_states = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            check("no_pready_after_rst", {up1_pready, down_psel}, 0);
        end

        resp_data = 32'h3141_5926;
        exp_dn.push_back(dn(0, 16'h0070, 32'h0));
        exp_up.push_back(up(0, 32'h3141_5926, 0, 1));
        do_xfer(0, 0, 16'h0070, 32'h0, 3);

        repeat (5) @(negedge pclk);
        check("up_queue_drained", exp_up.size(), 0);
        check("down_queue_drained", exp_dn.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
